// File: rtl/spio_spinnaker_link_rx_monitor_pkg.sv
// ---------------------------------------------------------------------------
// spio_spinnaker_link_rx_monitor_pkg
//
// Shared definitions for the SpiNNaker link receive side: packet field
// positions, NRZ 2-of-7 symbol codes, and the flit counts for short and
// long packets.
//
// Contents:
//   PKT_*            packet width and field positions (hdr/key/payload)
//   SYM_EOP          end-of-packet transition code
//   FLITS_SHORT/LONG nibble counts for 40-bit and 72-bit packets
//   rx_state_e       receive FSM state encoding
//   nibble_code()    2-of-7 transition code for a data nibble
//   two_or_more()    true when at least two wires have toggled
// ---------------------------------------------------------------------------
package spio_spinnaker_link_rx_monitor_pkg;

    localparam int PKT_W        = 72;
    localparam int PKT_HDR_LSB  = 0;
    localparam int PKT_KEY_LSB  = 8;
    localparam int PKT_PLD_LSB  = 40;
    localparam int HDR_LONG_BIT = 1;   // header bit selecting a payload-carrying packet

    localparam int SYM_W = 7;
    localparam logic [SYM_W-1:0] SYM_EOP = 7'b1100000;

    localparam logic [4:0] FLITS_SHORT = 5'd10;
    localparam logic [4:0] FLITS_LONG  = 5'd18;

    typedef enum logic [2:0] {
        ST_INIT,
        ST_COLLECT,
        ST_ACKWAIT,
        ST_DROP,
        ST_HOLD
    } rx_state_e;

    function automatic logic [SYM_W-1:0] nibble_code(input logic [3:0] nib);
        logic [SYM_W-1:0] code;
        code = '0;
        case (nib)
            4'h0: code = 7'b0010001;
            4'h1: code = 7'b0010010;
            4'h2: code = 7'b0010100;
            4'h3: code = 7'b0011000;
            4'h4: code = 7'b0100001;
            4'h5: code = 7'b0100010;
            4'h6: code = 7'b0100100;
            4'h7: code = 7'b0101000;
            4'h8: code = 7'b1000001;
            4'h9: code = 7'b1000010;
            4'ha: code = 7'b1000100;
            4'hb: code = 7'b1001000;
            4'hc: code = 7'b0000011;
            4'hd: code = 7'b0000110;
            4'he: code = 7'b0001100;
            4'hf: code = 7'b0001001;
        endcase
        return code;
    endfunction

    // Clearing the lowest set bit leaves something only if two or more were set.
    function automatic logic two_or_more(input logic [SYM_W-1:0] v);
        return (v & (v - 7'd1)) != 7'd0;
    endfunction

endpackage

// File: rtl/spio_2of7_decoder.sv
// ---------------------------------------------------------------------------
// spio_2of7_decoder
//
// Combinational NRZ 2-of-7 symbol decoder. The transition pattern is the XOR
// of the current wire state with the state at the last accepted symbol.
//
// Ports:
//   data_i      current (synchronised) link wires
//   old_data_i  link wires captured at the last accepted symbol
//   nibble_o    decoded data value (meaningful for data symbols only)
//   eop_o       transition pattern is the end-of-packet code
//   complete_o  at least two wires have toggled
//   invalid_o   complete, but neither a data code nor EOP
// ---------------------------------------------------------------------------
module spio_2of7_decoder
    import spio_spinnaker_link_rx_monitor_pkg::*;
(
    input  logic [SYM_W-1:0] data_i,
    input  logic [SYM_W-1:0] old_data_i,
    output logic [3:0]       nibble_o,
    output logic             eop_o,
    output logic             complete_o,
    output logic             invalid_o
);

    logic [SYM_W-1:0] x;
    logic [15:0]      match;

    assign x = data_i ^ old_data_i;

    genvar gi;
    generate
        for (gi = 0; gi < 16; gi++) begin : g_match
            assign match[gi] = (x == nibble_code(4'(gi)));
        end
    endgenerate

    // Codes are unique, so at most one match bit is set and OR-encoding is exact.
    always_comb begin
        nibble_o = '0;
        for (int i = 0; i < 16; i++) begin
            if (match[i]) begin
                nibble_o = nibble_o | 4'(i);
            end
        end
    end

    assign complete_o = two_or_more(x);
    assign eop_o      = (x == SYM_EOP);
    assign invalid_o  = complete_o && !eop_o && !(|match);

endmodule

// File: rtl/spio_spinnaker_link_rx_monitor.sv
// ---------------------------------------------------------------------------
// spio_spinnaker_link_rx_monitor
//
// Receive-side model of a SpiNNaker link: decodes the 2-of-7 symbol stream,
// returns the NRZ acknowledge after a programmable delay, reassembles
// 40/72-bit packets into a single-entry valid/ready slot, flags framing and
// parity errors, and counts packets and errors.
//
// Ports:
//   tb_clk, tb_rst     clock, asynchronous active-high reset
//   SL_DATA_2OF7_IN    link wires (already synchronised)
//   SL_ACK_OUT         link acknowledge, toggles once per accepted symbol
//   PKT_DATA_OUT       {payload[71:40], key[39:8], hdr[7:0]}
//   PKT_VLD_OUT        packet valid, held until PKT_RDY_IN
//   PKT_RDY_IN         downstream ready
//   PARITY_ERR_OUT     one-cycle pulse with delivery of an even-parity packet
//   FRAME_ERR_OUT      one-cycle pulse on bad flit count or bad symbol
//   PKT_CNT_OUT        delivered packets (wraps)
//   ERR_CNT_OUT        frame plus parity errors (wraps)
// ---------------------------------------------------------------------------
module spio_spinnaker_link_rx_monitor
    import spio_spinnaker_link_rx_monitor_pkg::*;
#(
    parameter int ACK_DLY = 4,   // 1..255
    parameter int CNT_W   = 16
) (
    input  logic             tb_clk,
    input  logic             tb_rst,
    input  logic [SYM_W-1:0] SL_DATA_2OF7_IN,
    output logic             SL_ACK_OUT,
    output logic [PKT_W-1:0] PKT_DATA_OUT,
    output logic             PKT_VLD_OUT,
    input  logic             PKT_RDY_IN,
    output logic             PARITY_ERR_OUT,
    output logic             FRAME_ERR_OUT,
    output logic [CNT_W-1:0] PKT_CNT_OUT,
    output logic [CNT_W-1:0] ERR_CNT_OUT
);

    // The counter is loaded on accept and the ack toggles when it is seen at
    // zero, so loading ACK_DLY-1 puts the toggle ACK_DLY edges after accept.
    localparam logic [7:0] ACK_LOAD = 8'(ACK_DLY - 1);

    rx_state_e        state_q;
    logic             ret_drop_q;
    logic             init_wait_q;
    logic             ack_q;
    logic [SYM_W-1:0] old_data_q;
    logic [4:0]       fltc_q;
    logic [7:0]       ack_cnt_q;
    logic [PKT_W-1:0] shift_q;

    logic [PKT_W-1:0] pkt_data_q;
    logic             pkt_vld_q;
    logic             par_err_q;
    logic             frm_err_q;
    logic [CNT_W-1:0] pkt_cnt_q, pkt_cnt_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

    logic [3:0]       sym_nibble;
    logic             sym_eop;
    logic             sym_complete;
    logic             sym_invalid;

    logic             is_long;
    logic             count_ok;
    logic             slot_free;
    logic             parity_ok;
    logic             in_collect;
    logic             load_slot;
    logic             frame_err;
    logic             nib_we;
    logic [PKT_W-1:0] pkt_asm;

    spio_2of7_decoder u_dec (
        .data_i     (SL_DATA_2OF7_IN),
        .old_data_i (old_data_q),
        .nibble_o   (sym_nibble),
        .eop_o      (sym_eop),
        .complete_o (sym_complete),
        .invalid_o  (sym_invalid)
    );

    assign is_long   = shift_q[HDR_LONG_BIT];
    assign count_ok  = (fltc_q == (is_long ? FLITS_LONG : FLITS_SHORT));
    // Upper nibbles may hold a previous long packet; short packets mask them.
    assign pkt_asm   = is_long ? shift_q
                               : {{(PKT_W - PKT_PLD_LSB){1'b0}}, shift_q[PKT_PLD_LSB-1:0]};
    assign parity_ok = ^pkt_asm;
    // A slot being handed over this cycle counts as free, avoiding a bubble.
    assign slot_free = !pkt_vld_q || PKT_RDY_IN;
    assign in_collect = (state_q == ST_COLLECT) && sym_complete;

    always_comb begin
        load_slot = (in_collect && sym_eop && count_ok && slot_free)
                 || ((state_q == ST_HOLD) && slot_free);
        frame_err = in_collect
                 && (sym_invalid
                     || (sym_eop && !count_ok)
                     || (!sym_eop && (fltc_q == FLITS_LONG)));
        nib_we    = in_collect && !sym_eop && !sym_invalid && (fltc_q != FLITS_LONG);
    end

    // Receive FSM: symbol acceptance, flit counting and ack generation.
    always_ff @(posedge tb_clk or posedge tb_rst) begin
        if (tb_rst) begin
            state_q     <= ST_INIT;
            ret_drop_q  <= 1'b0;
            init_wait_q <= 1'b0;
            ack_q       <= 1'b0;
            old_data_q  <= '0;
            fltc_q      <= '0;
            ack_cnt_q   <= '0;
        end else begin
            case (state_q)
                ST_INIT: begin
                    if (!init_wait_q) begin
                        init_wait_q <= 1'b1;
                    end else begin
                        old_data_q <= SL_DATA_2OF7_IN;
                        ack_q      <= ~ack_q;
                        state_q    <= ST_COLLECT;
                    end
                end
                ST_COLLECT: begin
                    if (sym_complete) begin
                        old_data_q <= SL_DATA_2OF7_IN;
                        if (sym_eop && count_ok && !slot_free) begin
                            // EOP stays unacknowledged until the slot drains.
                            state_q <= ST_HOLD;
                        end else begin
                            ack_cnt_q <= ACK_LOAD;
                            state_q   <= ST_ACKWAIT;
                            if (sym_eop) begin
                                fltc_q     <= '0;
                                ret_drop_q <= 1'b0;
                            end else if (sym_invalid || (fltc_q == FLITS_LONG)) begin
                                ret_drop_q <= 1'b1;
                            end else begin
                                fltc_q     <= fltc_q + 5'd1;
                                ret_drop_q <= 1'b0;
                            end
                        end
                    end
                end
                ST_DROP: begin
                    if (sym_complete) begin
                        old_data_q <= SL_DATA_2OF7_IN;
                        ack_cnt_q  <= ACK_LOAD;
                        state_q    <= ST_ACKWAIT;
                        if (sym_eop) begin
                            fltc_q     <= '0;
                            ret_drop_q <= 1'b0;
                        end else begin
                            ret_drop_q <= 1'b1;
                        end
                    end
                end
                ST_ACKWAIT: begin
                    if (ack_cnt_q == 8'd0) begin
                        ack_q   <= ~ack_q;
                        state_q <= ret_drop_q ? ST_DROP : ST_COLLECT;
                    end else begin
                        ack_cnt_q <= ack_cnt_q - 8'd1;
                    end
                end
                ST_HOLD: begin
                    if (slot_free) begin
                        fltc_q     <= '0;
                        ack_cnt_q  <= ACK_LOAD;
                        ret_drop_q <= 1'b0;
                        state_q    <= ST_ACKWAIT;
                    end
                end
                default: begin
                    state_q <= ST_INIT;
                end
            endcase
        end
    end

    // Nibble assembly, least-significant nibble first.
    always_ff @(posedge tb_clk or posedge tb_rst) begin
        if (tb_rst) begin
            shift_q <= '0;
        end else if (nib_we) begin
            for (int i = 0; i < int'(FLITS_LONG); i++) begin
                if (fltc_q == 5'(i)) begin
                    shift_q[4*i +: 4] <= sym_nibble;
                end
            end
        end
    end

    assign pkt_cnt_d = pkt_cnt_q + CNT_W'(load_slot);
    assign err_cnt_d = err_cnt_q + CNT_W'(frame_err) + CNT_W'(load_slot && !parity_ok);

    // Output slot, error pulses and counters.
    always_ff @(posedge tb_clk or posedge tb_rst) begin
        if (tb_rst) begin
            pkt_data_q <= '0;
            pkt_vld_q  <= 1'b0;
            par_err_q  <= 1'b0;
            frm_err_q  <= 1'b0;
            pkt_cnt_q  <= '0;
            err_cnt_q  <= '0;
        end else begin
            par_err_q <= load_slot && !parity_ok;
            frm_err_q <= frame_err;
            pkt_cnt_q <= pkt_cnt_d;
            err_cnt_q <= err_cnt_d;
            if (load_slot) begin
                pkt_data_q <= pkt_asm;
                pkt_vld_q  <= 1'b1;
            end else if (PKT_RDY_IN) begin
                pkt_vld_q  <= 1'b0;
            end
        end
    end

    assign SL_ACK_OUT     = ack_q;
    assign PKT_DATA_OUT   = pkt_data_q;
    assign PKT_VLD_OUT    = pkt_vld_q;
    assign PARITY_ERR_OUT = par_err_q;
    assign FRAME_ERR_OUT  = frm_err_q;
    assign PKT_CNT_OUT    = pkt_cnt_q;
    assign ERR_CNT_OUT    = err_cnt_q;

endmodule

// File: tb/tb_spio_spinnaker_link_rx_monitor.sv
// ---------------------------------------------------------------------------
// tb_spio_spinnaker_link_rx_monitor
//
// Directed bench: a table of packets with hand-computed expected slot
// contents and parity flags, then hand-written sequences for backpressure,
// framing errors, flit overflow and reset in the middle of a packet.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_spio_spinnaker_link_rx_monitor;

    localparam int ACK_DLY = 4;
    localparam int CNT_W   = 16;
    localparam logic [6:0] EOP_SYM = 7'b1100000;
    localparam logic [6:0] BAD_SYM = 7'b1010000;

    logic             tb_clk = 1'b0;
    logic             tb_rst = 1'b1;
    logic [6:0]       link_data = '0;
    logic             sl_ack;
    logic [71:0]      pkt_data;
    logic             pkt_vld;
    logic             pkt_rdy = 1'b1;
    logic             par_err;
    logic             frm_err;
    logic [CNT_W-1:0] pkt_cnt;
    logic [CNT_W-1:0] err_cnt;

    spio_spinnaker_link_rx_monitor #(
        .ACK_DLY (ACK_DLY),
        .CNT_W   (CNT_W)
    ) dut (
        .tb_clk          (tb_clk),
        .tb_rst          (tb_rst),
        .SL_DATA_2OF7_IN (link_data),
        .SL_ACK_OUT      (sl_ack),
        .PKT_DATA_OUT    (pkt_data),
        .PKT_VLD_OUT     (pkt_vld),
        .PKT_RDY_IN      (pkt_rdy),
        .PARITY_ERR_OUT  (par_err),
        .FRAME_ERR_OUT   (frm_err),
        .PKT_CNT_OUT     (pkt_cnt),
        .ERR_CNT_OUT     (err_cnt)
    );

    always #5 tb_clk = ~tb_clk;

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    int n_vec = 0;
    int n_err = 0;

    // ---------------- passive monitor (samples on the falling edge) --------
    logic [71:0] got_q[$];
    int          par_cnt = 0;
    int          par_first_cnt = 0;
    int          frm_cnt = 0;
    int          stall_chg = 0;
    logic        prev_vld = 1'b0;
    logic        prev_hs = 1'b0;
    logic        prev_stall = 1'b0;
    logic [71:0] prev_data = '0;

    always @(negedge tb_clk) begin
        if (pkt_vld && pkt_rdy) got_q.push_back(pkt_data);
        if (par_err) par_cnt <= par_cnt + 1;
        if (par_err && pkt_vld && (!prev_vld || prev_hs)) par_first_cnt <= par_first_cnt + 1;
        if (frm_err) frm_cnt <= frm_cnt + 1;
        if (prev_stall && pkt_vld && (pkt_data != prev_data)) stall_chg <= stall_chg + 1;
        prev_vld   <= pkt_vld;
        prev_hs    <= pkt_vld && pkt_rdy;
        prev_stall <= pkt_vld && !pkt_rdy;
        prev_data  <= pkt_data;
    end

    // ---------------- helpers ----------------------------------------------
    logic ack_seen = 1'b0;

    function automatic logic [6:0] code_of(input logic [3:0] n);
        logic [6:0] c;
        c = '0;
        case (n)
            4'h0: c = 7'b0010001; 4'h1: c = 7'b0010010;
            4'h2: c = 7'b0010100; 4'h3: c = 7'b0011000;
            4'h4: c = 7'b0100001; 4'h5: c = 7'b0100010;
            4'h6: c = 7'b0100100; 4'h7: c = 7'b0101000;
            4'h8: c = 7'b1000001; 4'h9: c = 7'b1000010;
            4'ha: c = 7'b1000100; 4'hb: c = 7'b1001000;
            4'hc: c = 7'b0000011; 4'hd: c = 7'b0000110;
            4'he: c = 7'b0001100; 4'hf: c = 7'b0001001;
        endcase
        return c;
    endfunction

    task automatic tick();
        @(posedge tb_clk);
        #1;
    endtask

    task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end else begin
            $display("ok   %s: 0x%0h", name, act);
        end
    endtask

    task automatic wait_ack(input int max_cyc, output int lat, output bit seen);
        seen = 1'b0;
        lat  = 0;
        for (int c = 1; c <= max_cyc; c++) begin
            tick();
            if (sl_ack !== ack_seen) begin
                seen     = 1'b1;
                lat      = c;
                ack_seen = sl_ack;
                break;
            end
        end
    endtask

    // Drive one symbol just after an edge; the DUT is back in its receive
    // state, so it accepts on the next edge and acks ACK_DLY edges later.
    task automatic send_sym(input string name, input logic [6:0] code);
        int lat;
        bit seen;
        link_data = link_data ^ code;
        wait_ack(100, lat, seen);
        check({name, "_ack_lat"}, 72'(lat), 72'(ACK_DLY + 1));
    endtask

    task automatic send_nibbles(input logic [71:0] word, input int first, input int count);
        for (int i = first; i < first + count; i++) begin
            send_sym("nib", code_of(word[4*i +: 4]));
        end
    endtask

    task automatic send_pkt(input logic [71:0] word);
        send_nibbles(word, 0, word[1] ? 18 : 10);
        send_sym("eop", EOP_SYM);
    endtask

    task automatic expect_pkt(input string name, input logic [71:0] exp);
        logic [71:0] d;
        check({name, "_present"}, 72'(got_q.size() != 0), 72'd1);
        if (got_q.size() != 0) begin
            d = got_q.pop_front();
            check({name, "_data"}, d, exp);
        end
    endtask

    // ---------------- vector table -----------------------------------------
    typedef struct {
        logic [71:0] word;      // {payload, key, hdr} as sent (payload ignored when short)
        logic [71:0] exp_data;  // expected slot contents
        logic        exp_par;   // expected parity-error pulse
    } vec_t;

    vec_t             vecs [6];
    logic [CNT_W-1:0] exp_pkt;
    logic [CNT_W-1:0] exp_err;
    int               p0, pf0, f0;
    int               lat;
    bit               seen;

    initial begin
        vecs[0] = '{72'h000000000000000100, 72'h000000000000000100, 1'b0};
        vecs[1] = '{72'ha5a5a5a51234567803, 72'ha5a5a5a51234567803, 1'b0};
        vecs[2] = '{72'h000000000000000300, 72'h000000000000000300, 1'b1};
        vecs[3] = '{72'hffffffffdeadbeef01, 72'h00000000deadbeef01, 1'b0};
        vecs[4] = '{72'h000000010000000002, 72'h000000010000000002, 1'b1};
        vecs[5] = '{72'h00000000ffffffff80, 72'h00000000ffffffff80, 1'b0};
        exp_pkt = '0;
        exp_err = '0;

        // ---- reset state and initial ack ----
        tick();
        tick();
        check("rst_ack",     72'(sl_ack),   72'd0);
        check("rst_vld",     72'(pkt_vld),  72'd0);
        check("rst_data",    pkt_data,      72'd0);
        check("rst_par",     72'(par_err),  72'd0);
        check("rst_frm",     72'(frm_err),  72'd0);
        check("rst_pkt_cnt", 72'(pkt_cnt),  72'd0);
        check("rst_err_cnt", 72'(err_cnt),  72'd0);
        tb_rst = 1'b0;
        tick();
        check("init_ack_edge1", 72'(sl_ack), 72'd0);
        tick();
        check("init_ack_edge2", 72'(sl_ack), 72'd1);
        ack_seen = 1'b1;

        // ---- table-driven packets ----
        for (int i = 0; i < 6; i++) begin
            p0  = par_cnt;
            pf0 = par_first_cnt;
            f0  = frm_cnt;
            send_pkt(vecs[i].word);
            tick();
            expect_pkt($sformatf("vec%0d", i), vecs[i].exp_data);
            exp_pkt = exp_pkt + 1'b1;
            exp_err = exp_err + CNT_W'(vecs[i].exp_par);
            check($sformatf("vec%0d_par", i),       72'(par_cnt - p0),       72'(vecs[i].exp_par));
            check($sformatf("vec%0d_par_first", i), 72'(par_first_cnt - pf0), 72'(vecs[i].exp_par));
            check($sformatf("vec%0d_frm", i),       72'(frm_cnt - f0),       72'd0);
            check($sformatf("vec%0d_pkt_cnt", i),   72'(pkt_cnt),            72'(exp_pkt));
            check($sformatf("vec%0d_err_cnt", i),   72'(err_cnt),            72'(exp_err));
        end

        // ---- backpressure across two packets ----
        pkt_rdy = 1'b0;
        p0 = stall_chg;
        send_nibbles(72'h000000000000000700, 0, 10);
        link_data = link_data ^ EOP_SYM;
        tick();
        check("bp_a_vld_latency", 72'(pkt_vld), 72'd1);
        check("bp_a_data",        pkt_data,     72'h000000000000000700);
        wait_ack(100, lat, seen);
        check("bp_a_eop_ack_lat", 72'(lat), 72'(ACK_DLY));
        send_nibbles(72'h000000010000000003, 0, 18);
        link_data = link_data ^ EOP_SYM;
        wait_ack(40, lat, seen);
        check("bp_b_eop_held",   72'(seen),     72'd0);
        check("bp_stall_vld",    72'(pkt_vld),  72'd1);
        check("bp_stall_data",   pkt_data,      72'h000000000000000700);
        pkt_rdy = 1'b1;
        wait_ack(20, lat, seen);
        check("bp_b_eop_ack_lat", 72'(lat), 72'(ACK_DLY + 1));
        tick();
        expect_pkt("bp_first",  72'h000000000000000700);
        expect_pkt("bp_second", 72'h000000010000000003);
        exp_pkt = exp_pkt + 2'd2;
        check("bp_stall_stable", 72'(stall_chg - p0), 72'd0);
        check("bp_pkt_cnt",      72'(pkt_cnt),        72'(exp_pkt));

        // ---- EOP after 7 nibbles ----
        f0 = frm_cnt;
        send_nibbles(72'h000000000000001100, 0, 7);
        send_sym("short_eop", EOP_SYM);
        tick();
        exp_err = exp_err + 1'b1;
        check("frm7_pulse",   72'(frm_cnt - f0),  72'd1);
        check("frm7_no_pkt",  72'(got_q.size()),  72'd0);
        check("frm7_pkt_cnt", 72'(pkt_cnt),       72'(exp_pkt));
        check("frm7_err_cnt", 72'(err_cnt),       72'(exp_err));

        // ---- invalid code mid-packet, drop until EOP, then recover ----
        f0 = frm_cnt;
        send_nibbles(72'h000000000000004200, 0, 3);
        send_sym("invalid", BAD_SYM);
        send_nibbles(72'h000000000000004200, 3, 7);
        send_sym("drop_eop", EOP_SYM);
        tick();
        exp_err = exp_err + 1'b1;
        check("inv_pulse",   72'(frm_cnt - f0), 72'd1);
        check("inv_no_pkt",  72'(got_q.size()), 72'd0);
        check("inv_err_cnt", 72'(err_cnt),      72'(exp_err));
        send_pkt(72'h000000000000000b00);
        tick();
        expect_pkt("recover", 72'h000000000000000b00);
        exp_pkt = exp_pkt + 1'b1;
        check("recover_pkt_cnt", 72'(pkt_cnt), 72'(exp_pkt));

        // ---- 19th nibble on a long packet ----
        f0 = frm_cnt;
        send_nibbles(72'ha5a5a5a51234567803, 0, 18);
        send_sym("extra_nib", code_of(4'h5));
        send_sym("ovf_eop", EOP_SYM);
        tick();
        exp_err = exp_err + 1'b1;
        check("ovf_pulse",   72'(frm_cnt - f0), 72'd1);
        check("ovf_no_pkt",  72'(got_q.size()), 72'd0);
        check("ovf_err_cnt", 72'(err_cnt),      72'(exp_err));

        // ---- reset after 5 nibbles ----
        send_nibbles(72'h000000000000003c00, 0, 5);
        tb_rst = 1'b1;
        #1;
        check("mid_rst_ack",     72'(sl_ack),  72'd0);
        check("mid_rst_vld",     72'(pkt_vld), 72'd0);
        check("mid_rst_data",    pkt_data,     72'd0);
        check("mid_rst_pkt_cnt", 72'(pkt_cnt), 72'd0);
        check("mid_rst_err_cnt", 72'(err_cnt), 72'd0);
        tick();
        tb_rst   = 1'b0;
        ack_seen = 1'b0;
        exp_pkt  = '0;
        exp_err  = '0;
        tick();
        check("reinit_ack_edge1", 72'(sl_ack), 72'd0);
        tick();
        check("reinit_ack_edge2", 72'(sl_ack), 72'd1);
        ack_seen = 1'b1;
        send_pkt(vecs[1].word);
        tick();
        expect_pkt("post_rst", vecs[1].exp_data);
        exp_pkt = exp_pkt + 1'b1;
        check("post_rst_pkt_cnt", 72'(pkt_cnt), 72'(exp_pkt));
        check("post_rst_err_cnt", 72'(err_cnt), 72'(exp_err));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
